// File: rtl/mem_port_arbiter.sv
// Arbitrates one variable-latency memory between the instruction-fetch and load/store ports.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise data has fixed priority over fetch.
module mem_port_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_if_req,
   input  logic [ADDR_W-1:0] i_if_addr,
   output logic [DATA_W-1:0] o_if_rdata,
   output logic              o_if_valid,
   input  logic              i_d_req,
   input  logic              i_d_we,
   input  logic [ADDR_W-1:0] i_d_addr,
   input  logic [DATA_W-1:0] i_d_wdata,
   output logic [DATA_W-1:0] o_d_rdata,
   output logic              o_d_valid,
   output logic              o_m_req,
   output logic              o_m_we,
   output logic [ADDR_W-1:0] o_m_addr,
   output logic [DATA_W-1:0] o_m_wdata,
   input  logic [DATA_W-1:0] i_m_rdata,
   input  logic              i_m_ack,
   output logic              o_err,
   output logic              o_grant_d
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam int CNT_LAST_INT = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_LAST_INT);

   logic [1:0]        r_state;
   logic              r_mReq;
   logic              r_mWe;
   logic [ADDR_W-1:0] r_mAddr;
   logic [DATA_W-1:0] r_mWdata;
   logic [DATA_W-1:0] r_ifRdata;
   logic [DATA_W-1:0] r_dRdata;
   logic              r_grantD;
   logic              r_errFlag;
   logic [CNT_W-1:0]  r_cnt;

   logic w_pickD;
   logic w_anyReq;
   logic w_timeout;

   assign w_anyReq  = i_if_req | i_d_req;
   assign w_timeout = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

`ifdef MEM_ARB_RR_EN
   // Pointer set means data wins a tie; it flips toward whichever port was not just served.
   logic r_ptrD;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptrD <= 1'b1;
      end else if (r_state == S_DONE) begin
         r_ptrD <= ~r_grantD;
      end
   end

   assign w_pickD = i_d_req & (~i_if_req | r_ptrD);
`else
   // Data is the older instruction in the pipeline, so serving it first avoids deadlock.
   assign w_pickD = i_d_req;
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_mReq    <= 1'b0;
         r_mWe     <= 1'b0;
         r_mAddr   <= '0;
         r_mWdata  <= '0;
         r_ifRdata <= '0;
         r_dRdata  <= '0;
         r_grantD  <= 1'b0;
         r_errFlag <= 1'b0;
         r_cnt     <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_anyReq) begin
                  r_grantD  <= w_pickD;
                  r_mReq    <= 1'b1;
                  r_mWe     <= w_pickD & i_d_we;
                  r_mAddr   <= w_pickD ? i_d_addr : i_if_addr;
                  r_mWdata  <= w_pickD ? i_d_wdata : '0;
                  r_cnt     <= '0;
                  r_errFlag <= 1'b0;
                  r_state   <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               // An ack arriving in the final timeout cycle still wins.
               if (i_m_ack) begin
                  r_mReq  <= 1'b0;
                  r_state <= S_DONE;
                  if (!r_grantD) begin
                     r_ifRdata <= i_m_rdata;
                  end else if (!r_mWe) begin
                     r_dRdata <= i_m_rdata;
                  end
               end else if (w_timeout) begin
                  r_mReq    <= 1'b0;
                  r_errFlag <= 1'b1;
                  r_state   <= S_DONE;
                  if (!r_grantD) begin
                     r_ifRdata <= ERR_DATA;
                  end else if (!r_mWe) begin
                     r_dRdata <= ERR_DATA;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
               r_mReq  <= 1'b0;
            end
         endcase
      end
   end

   assign o_m_req    = r_mReq;
   assign o_m_we     = r_mWe;
   assign o_m_addr   = r_mAddr;
   assign o_m_wdata  = r_mWdata;
   assign o_if_rdata = r_ifRdata;
   assign o_d_rdata  = r_dRdata;
   assign o_grant_d  = r_grantD;
   assign o_if_valid = (r_state == S_DONE) & ~r_grantD;
   assign o_d_valid  = (r_state == S_DONE) & r_grantD;
   assign o_err      = (r_state == S_DONE) & r_errFlag;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a vector table of single accesses plus hand sequences
// for contention, sustained data traffic, mid-access reset and stray acks.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 4;

`ifdef MEM_ARB_RR_EN
   localparam int EXP_IF_DURING_DATA = 9;
`else
   localparam int EXP_IF_DURING_DATA = 0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          ifReq;
   logic [AW-1:0] ifAddr;
   logic [DW-1:0] ifRdata;
   logic          ifValid;
   logic          dReq;
   logic          dWe;
   logic [AW-1:0] dAddr;
   logic [DW-1:0] dWdata;
   logic [DW-1:0] dRdata;
   logic          dValid;
   logic          mReq;
   logic          mWe;
   logic [AW-1:0] mAddr;
   logic [DW-1:0] mWdata;
   logic [DW-1:0] mRdata;
   logic          mAck;
   logic          err;
   logic          grantD;

   mem_port_arbiter #(
      .ADDR_W  (AW),
      .DATA_W  (DW),
      .TIMEOUT (TMO),
      .ERR_DATA(32'hDEADBEEF)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_if_req  (ifReq),
      .i_if_addr (ifAddr),
      .o_if_rdata(ifRdata),
      .o_if_valid(ifValid),
      .i_d_req   (dReq),
      .i_d_we    (dWe),
      .i_d_addr  (dAddr),
      .i_d_wdata (dWdata),
      .o_d_rdata (dRdata),
      .o_d_valid (dValid),
      .o_m_req   (mReq),
      .o_m_we    (mWe),
      .o_m_addr  (mAddr),
      .o_m_wdata (mWdata),
      .i_m_rdata (mRdata),
      .i_m_ack   (mAck),
      .o_err     (err),
      .o_grant_d (grantD)
   );

   typedef struct {
      logic        isData;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ackAt;
      logic [31:0] rdata;
      logic [31:0] expRdata;
      logic        expErr;
      int          expLat;
      int          expMreq;
   } vec_t;

   vec_t vecs[6];
   int   errors = 0;
   int   checks = 0;
   logic autoAck = 1'b0;

   // Every comparison goes through here so the counters stay consistent.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Advance one cycle, sampling just after the edge; optionally act as a zero-wait memory.
   task automatic tick();
      @(posedge clk);
      #1;
      if (autoAck) begin
         mAck   = mReq;
         mRdata = mAddr ^ 32'hA5A50000;
      end
   endtask

   // Runs one access from the vector table, playing the memory with a per-vector ack cycle.
   task automatic applyStimulus(input vec_t v, input string tag);
      int          cyc;
      int          mreqCyc;
      int          lat;
      logic        gotIf;
      logic        gotD;
      logic [31:0] firstAddr;
      logic        firstWe;
      logic [31:0] firstWdata;
      logic [31:0] rd;
      logic        errSeen;
      logic        grantSeen;
      cyc = 0; mreqCyc = 0; lat = -1; gotIf = 0; gotD = 0;
      firstAddr = '0; firstWe = 0; firstWdata = '0; rd = '0; errSeen = 0; grantSeen = 0;
      if (v.isData) begin
         dReq = 1; dWe = v.we; dAddr = v.addr; dWdata = v.wdata;
      end else begin
         ifReq = 1; ifAddr = v.addr;
      end
      while (lat < 0 && cyc < 40) begin
         tick();
         cyc++;
         mAck = 0;
         if (mReq) begin
            mreqCyc++;
            if (mreqCyc == 1) begin
               firstAddr = mAddr; firstWe = mWe; firstWdata = mWdata;
            end
            if (mreqCyc == v.ackAt) begin
               mAck = 1; mRdata = v.rdata;
            end
         end
         if (ifValid || dValid) begin
            lat = cyc; gotIf = ifValid; gotD = dValid;
            rd = v.isData ? dRdata : ifRdata;
            errSeen = err; grantSeen = grantD;
         end
      end
      checkOutput({tag, " validPort"}, {30'd0, gotD, gotIf}, v.isData ? 32'd2 : 32'd1);
      checkOutput({tag, " latency"}, 32'(lat), 32'(v.expLat));
      checkOutput({tag, " mReqCycles"}, 32'(mreqCyc), 32'(v.expMreq));
      checkOutput({tag, " mAddr"}, firstAddr, v.addr);
      checkOutput({tag, " mWe"}, {31'd0, firstWe}, {31'd0, v.we});
      if (v.we) checkOutput({tag, " mWdata"}, firstWdata, v.wdata);
      else      checkOutput({tag, " rdata"}, rd, v.expRdata);
      checkOutput({tag, " err"}, {31'd0, errSeen}, {31'd0, v.expErr});
      checkOutput({tag, " grantD"}, {31'd0, grantSeen}, {31'd0, v.isData});
      ifReq = 0; dReq = 0; dWe = 0; mAck = 0;
      tick();
      checkOutput({tag, " idleAfter"}, {29'd0, mReq, ifValid, dValid}, 32'd0);
   endtask

   initial begin
      int dOrder, ifOrder, seen, dCnt, ifCnt;
      logic [31:0] dGot, ifGot;
      logic anyBad;
      vec_t late;

      vecs[0] = '{1'b0, 1'b0, 32'h40,  32'h0,        3, 32'h2008000A, 32'h2008000A, 1'b0, 4, 3};
      vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h0,        1, 32'h11112222, 32'h11112222, 1'b0, 2, 1};
      vecs[2] = '{1'b1, 1'b1, 32'h200, 32'hCAFEF00D, 2, 32'h0,        32'h0,        1'b0, 3, 2};
      vecs[3] = '{1'b1, 1'b0, 32'h300, 32'h0,        0, 32'h0,        32'hDEADBEEF, 1'b1, 5, 4};
      vecs[4] = '{1'b1, 1'b0, 32'h304, 32'h0,        4, 32'h55AA55AA, 32'h55AA55AA, 1'b0, 5, 4};
      vecs[5] = '{1'b0, 1'b0, 32'h44,  32'h0,        0, 32'h0,        32'hDEADBEEF, 1'b1, 5, 4};

      rst = 1; ifReq = 0; ifAddr = '0; dReq = 0; dWe = 0; dAddr = '0; dWdata = '0;
      mRdata = '0; mAck = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 0;
      checkOutput("reset flags", {27'd0, mReq, mWe, ifValid, dValid, err}, 32'd0);
      checkOutput("reset grantD", {31'd0, grantD}, 32'd0);
      checkOutput("reset ifRdata", ifRdata, 32'd0);
      checkOutput("reset dRdata", dRdata, 32'd0);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(vecs[i], $sformatf("vec%0d", i));
      end

      // Both ports request at once; record which valid arrives first.
      autoAck = 1;
      ifReq = 1; ifAddr = 32'h80; dReq = 1; dWe = 0; dAddr = 32'h100;
      dOrder = -1; ifOrder = -1; seen = 0; dGot = '0; ifGot = '0;
      for (int c = 0; c < 40 && (ifReq || dReq); c++) begin
         tick();
         if (dValid) begin dOrder = seen; seen++; dGot = dRdata; dReq = 0; end
         if (ifValid) begin ifOrder = seen; seen++; ifGot = ifRdata; ifReq = 0; end
      end
      checkOutput("contend dOrder", 32'(dOrder), 32'd0);
      checkOutput("contend ifOrder", 32'(ifOrder), 32'd1);
      checkOutput("contend dRdata", dGot, 32'hA5A50100);
      checkOutput("contend ifRdata", ifGot, 32'hA5A50080);
      tick();

      // Data held for ten accesses while fetch waits.
      ifReq = 1; ifAddr = 32'hC0; dReq = 1; dWe = 0; dAddr = 32'h180; dCnt = 0; ifCnt = 0;
      for (int c = 0; c < 200 && dCnt < 10; c++) begin
         tick();
         if (dValid) dCnt++;
         if (ifValid) ifCnt++;
      end
      dReq = 0;
      checkOutput("holdData dCount", 32'(dCnt), 32'd10);
      checkOutput("holdData ifCount", 32'(ifCnt), 32'(EXP_IF_DURING_DATA));
      for (int c = 0; c < 40 && ifReq; c++) begin
         tick();
         if (ifValid) ifReq = 0;
      end
      checkOutput("holdData fetchDrain", {31'd0, ifReq}, 32'd0);
      tick();
      autoAck = 0; mAck = 0;
      tick();

      // Reset during ISSUE abandons the access without a valid.
      dReq = 1; dWe = 0; dAddr = 32'h400;
      for (int c = 0; c < 5 && !mReq; c++) tick();
      tick();
      checkOutput("midReset issuing", {31'd0, mReq}, 32'd1);
      rst = 1; dReq = 0;
      tick();
      rst = 0;
      checkOutput("midReset after", {29'd0, mReq, ifValid, dValid}, 32'd0);
      anyBad = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (mReq || ifValid || dValid || err) anyBad = 1;
      end
      checkOutput("midReset quiet", {31'd0, anyBad}, 32'd0);
      late = '{1'b1, 1'b0, 32'h404, 32'h0, 1, 32'h12345678, 32'h12345678, 1'b0, 2, 1};
      applyStimulus(late, "postReset");

      // A stray ack with no outstanding request must be ignored.
      mAck = 1; mRdata = 32'hFFFFFFFF;
      tick();
      mAck = 0;
      checkOutput("strayAck state", {28'd0, mReq, ifValid, dValid, err}, 32'd0);
      tick();
      checkOutput("strayAck later", {28'd0, mReq, ifValid, dValid, err}, 32'd0);
      checkOutput("strayAck dRdata", dRdata, 32'h12345678);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
